// File: rtl/acc_datapath.sv
// rtl/acc_datapath.sv - accumulator, carry flag, register file and ALU driven by the decoder control word
// Optional feature: define ACC_ZFLAG_EN to add the Z register and z_out port.
module acc_datapath #(
    parameter int WIDTH     = 8,
    parameter int REG_COUNT = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [3:0]       RegAddr,
    input  logic [2:0]       ALUCode,
    input  logic             Reg_CE,
    input  logic             CY_CE,
    input  logic             A_CE,
    input  logic             ResetCY,
    input  logic             ext_we,
    input  logic [3:0]       ext_addr,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] acc_out,
`ifdef ACC_ZFLAG_EN
    output logic             z_out,
`endif
    output logic             cy_out
);

    typedef enum logic [2:0] {
        OP_LD  = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_NOT = 3'b110,
        OP_NOP = 3'b111
    } alu_op_t;

    logic [WIDTH-1:0] regs [REG_COUNT];
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Operand is the pre-write value; there is deliberately no write-to-read bypass.
    assign opnd_r = regs[RegAddr];
    assign sum    = {1'b0, acc} + {1'b0, opnd_r} + {{WIDTH{1'b0}}, cy};
    assign diff   = {1'b0, acc} - {1'b0, opnd_r} - {{WIDTH{1'b0}}, cy};

    always_comb begin
        res  = acc;
        cout = 1'b0;
        case (alu_op_t'(ALUCode))
            OP_LD:   res = opnd_r;
            OP_ADD:  {cout, res} = sum;
            OP_SUB:  {cout, res} = diff;
            OP_AND:  res = acc & opnd_r;
            OP_OR:   res = acc | opnd_r;
            OP_XOR:  res = acc ^ opnd_r;
            OP_NOT:  res = ~acc;
            default: begin
                res  = acc;
                cout = cy;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            acc <= '0;
            cy  <= 1'b0;
        end else begin
            if (A_CE)
                acc <= res;
            if (ResetCY)
                cy <= 1'b0;
            else if (CY_CE)
                cy <= cout;
        end
    end

    // The external write is issued last so it wins an address collision with Reg_CE.
    always_ff @(posedge clk) begin
        if (nReset) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else begin
            if (Reg_CE)
                regs[RegAddr] <= acc;
            if (ext_we)
                regs[ext_addr] <= ext_data;
        end
    end

`ifdef ACC_ZFLAG_EN
    logic z;

    always_ff @(posedge clk) begin
        if (nReset)
            z <= 1'b0;
        else if (CY_CE)
            z <= (res == '0);
    end

    assign z_out = z;
`endif

    assign dbg_data = regs[dbg_addr];
    assign acc_out  = acc;
    assign cy_out   = cy;

endmodule

// File: tb/tb_acc_datapath.sv
// tb/tb_acc_datapath.sv - directed self-checking bench for acc_datapath
module tb_acc_datapath;

    logic       clk = 1'b0;
    logic       nReset;
    logic [3:0] RegAddr;
    logic [2:0] ALUCode;
    logic       Reg_CE, CY_CE, A_CE, ResetCY;
    logic       ext_we;
    logic [3:0] ext_addr;
    logic [7:0] ext_data;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [7:0] acc_out;
    logic       cy_out;
`ifdef ACC_ZFLAG_EN
    logic       z_out;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    acc_datapath #(.WIDTH(8), .REG_COUNT(16)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .RegAddr  (RegAddr),
        .ALUCode  (ALUCode),
        .Reg_CE   (Reg_CE),
        .CY_CE    (CY_CE),
        .A_CE     (A_CE),
        .ResetCY  (ResetCY),
        .ext_we   (ext_we),
        .ext_addr (ext_addr),
        .ext_data (ext_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .acc_out  (acc_out),
`ifdef ACC_ZFLAG_EN
        .z_out    (z_out),
`endif
        .cy_out   (cy_out)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        nReset  = 1'b0;
        RegAddr = 4'hF;
        ALUCode = 3'b111;
        Reg_CE  = 1'b0;
        CY_CE   = 1'b0;
        A_CE    = 1'b0;
        ResetCY = 1'b0;
        ext_we  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic ext_wr(input logic [3:0] a, input logic [7:0] d);
        ext_we   = 1'b1;
        ext_addr = a;
        ext_data = d;
    endtask

    task automatic word(input logic [3:0] ra, input logic [2:0] op,
                        input logic a_ce, input logic cy_ce, input logic r_ce);
        RegAddr = ra;
        ALUCode = op;
        A_CE    = a_ce;
        CY_CE   = cy_ce;
        Reg_CE  = r_ce;
    endtask

    initial begin
        idle();
        ext_addr = '0;
        ext_data = '0;
        dbg_addr = '0;
        @(negedge clk);

        // random state, then reset
        for (int i = 0; i < 16; i++) begin
            ext_wr(i[3:0], 8'(i * 17 + 3));
            step();
        end
        for (int i = 0; i < 10; i++) begin
            RegAddr  = 4'($urandom);
            ALUCode  = 3'($urandom);
            A_CE     = 1'b1;
            CY_CE    = 1'b1;
            Reg_CE   = 1'($urandom);
            ext_we   = 1'($urandom);
            ext_addr = 4'($urandom);
            ext_data = 8'($urandom);
            step();
        end
        nReset = 1'b1;
        word(4'h2, 3'b001, 1'b1, 1'b1, 1'b1);
        ext_wr(4'h3, 8'hAA);
        step();
        check("reset_A", acc_out, 8'h00);
        check("reset_CY", {7'b0, cy_out}, 8'h00);
`ifdef ACC_ZFLAG_EN
        check("reset_Z", {7'b0, z_out}, 8'h00);
`endif
        for (int i = 0; i < 16; i++)
            check_reg($sformatf("reset_reg%0d", i), i[3:0], 8'h00);

        // preload and LD
        ext_wr(4'h1, 8'h05);
        step();
        check("preload_A_hold", acc_out, 8'h00);
        check_reg("preload_reg1", 4'h1, 8'h05);
        word(4'h1, 3'b000, 1'b1, 1'b0, 1'b0);
        step();
        check("ld_A", acc_out, 8'h05);
        check("ld_CY", {7'b0, cy_out}, 8'h00);

        // ADD with carry in/out
        ext_wr(4'h0, 8'hF0);
        step();
        word(4'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        ext_wr(4'h2, 8'h20);
        step();
        check("setup_F0", acc_out, 8'hF0);
        word(4'h2, 3'b001, 1'b1, 1'b1, 1'b0);
        step();
        check("add1_A", acc_out, 8'h10);
        check("add1_CY", {7'b0, cy_out}, 8'h01);
        word(4'h2, 3'b001, 1'b1, 1'b1, 1'b0);
        step();
        check("add2_A", acc_out, 8'h31);
        check("add2_CY", {7'b0, cy_out}, 8'h00);

        // exchange and write collisions
        ext_wr(4'h7, 8'h11);
        step();
        word(4'h7, 3'b000, 1'b1, 1'b0, 1'b0);
        ext_wr(4'h3, 8'h22);
        step();
        word(4'h3, 3'b000, 1'b1, 1'b0, 1'b1);
        step();
        check("xchg_A", acc_out, 8'h22);
        check_reg("xchg_reg3", 4'h3, 8'h11);
        word(4'h3, 3'b000, 1'b1, 1'b0, 1'b1);
        ext_wr(4'h3, 8'h99);
        step();
        check("xchg_ext_A", acc_out, 8'h11);
        check_reg("xchg_ext_reg3", 4'h3, 8'h99);
        word(4'h8, 3'b111, 1'b0, 1'b0, 1'b1);
        ext_wr(4'h9, 8'h5A);
        step();
        check_reg("dual_reg8", 4'h8, 8'h11);
        check_reg("dual_reg9", 4'h9, 8'h5A);
        check("dual_A", acc_out, 8'h11);

        // carry priority and idle word
        ext_wr(4'hA, 8'hFF);
        step();
        word(4'hA, 3'b000, 1'b1, 1'b0, 1'b0);
        ext_wr(4'h4, 8'h01);
        step();
        word(4'h4, 3'b001, 1'b1, 1'b1, 1'b0);
        ResetCY = 1'b1;
        step();
        check("prio_A", acc_out, 8'h00);
        check("prio_CY", {7'b0, cy_out}, 8'h00);
`ifdef ACC_ZFLAG_EN
        check("prio_Z", {7'b0, z_out}, 8'h01);
`endif
        step();
        check("idle_A", acc_out, 8'h00);
        check("idle_CY", {7'b0, cy_out}, 8'h00);
        check_reg("idle_reg15", 4'hF, 8'h00);
        check_reg("idle_reg4", 4'h4, 8'h01);

        // logic ops: 00|99=99, &01=01, ^FF=FE, ~=01
        word(4'h3, 3'b100, 1'b1, 1'b0, 1'b0);
        step();
        check("or_A", acc_out, 8'h99);
        word(4'h4, 3'b011, 1'b1, 1'b0, 1'b0);
        step();
        check("and_A", acc_out, 8'h01);
        word(4'hA, 3'b101, 1'b1, 1'b0, 1'b0);
        step();
        check("xor_A", acc_out, 8'hFE);
        word(4'h0, 3'b110, 1'b1, 1'b0, 1'b0);
        step();
        check("not_A", acc_out, 8'h01);

        // SUB and borrow
        ext_wr(4'hB, 8'h07);
        step();
        word(4'hB, 3'b000, 1'b1, 1'b0, 1'b0);
        ext_wr(4'h5, 8'h07);
        step();
        word(4'h5, 3'b010, 1'b1, 1'b1, 1'b0);
        step();
        check("sub1_A", acc_out, 8'h00);
        check("sub1_CY", {7'b0, cy_out}, 8'h00);
`ifdef ACC_ZFLAG_EN
        check("sub1_Z", {7'b0, z_out}, 8'h01);
`endif
        ext_wr(4'h6, 8'h01);
        step();
        word(4'h6, 3'b010, 1'b1, 1'b1, 1'b0);
        step();
        check("sub2_A", acc_out, 8'hFF);
        check("sub2_CY", {7'b0, cy_out}, 8'h01);
`ifdef ACC_ZFLAG_EN
        check("sub2_Z", {7'b0, z_out}, 8'h00);
`endif
        // NOP with CY_CE keeps the carry
        word(4'hF, 3'b111, 1'b1, 1'b1, 1'b0);
        step();
        check("nop_A", acc_out, 8'hFF);
        check("nop_CY", {7'b0, cy_out}, 8'h01);

        // mid-sequence reset, then first word after reset executes
        nReset = 1'b1;
        word(4'h6, 3'b001, 1'b1, 1'b1, 1'b1);
        ext_wr(4'h1, 8'h33);
        step();
        check("midrst_A", acc_out, 8'h00);
        check("midrst_CY", {7'b0, cy_out}, 8'h00);
        check_reg("midrst_reg1", 4'h1, 8'h00);
        word(4'h0, 3'b110, 1'b1, 1'b0, 1'b0);
        step();
        check("postrst_A", acc_out, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
